// File: rtl/crc48_frame_gen.sv
// Transmit framer: registers a 48-bit payload, runs a bit-serial CRC-16 over it MSB first,
// and presents {payload, crc} with a valid/ready handshake. Optional err_inj via CRC_ERR_INJECT_EN.
module crc48_frame_gen #(
    parameter logic [15:0] CRC_POLY = 16'h1021,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] din,
    input  logic        din_valid,
`ifdef CRC_ERR_INJECT_EN
    input  logic        err_inj,
`endif
    output logic        din_ready,
    output logic [63:0] frame_out,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [47:0] payload_q, payload_d;
    logic [15:0] crc_q, crc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] frame_q, frame_d;
    logic        frame_valid_q, frame_valid_d;
`ifdef CRC_ERR_INJECT_EN
    logic        err_q, err_d;
`endif

    logic        fb;
    logic [15:0] crc_step;
    logic [15:0] crc_final;

    // NOTE: the downstream compare path works on the falling edge, so every register does too.
    always_ff @(negedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            // NOTE: the payload register is reset as well; it is small and keeps frames deterministic.
            payload_q     <= '0;
            crc_q         <= CRC_INIT;
            cnt_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
`ifdef CRC_ERR_INJECT_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            payload_q     <= payload_d;
            crc_q         <= crc_d;
            cnt_q         <= cnt_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
`ifdef CRC_ERR_INJECT_EN
            err_q         <= err_d;
`endif
        end
    end

    // One shift of a non-reflected, non-augmented CRC: feedback is the outgoing MSB xor the data bit.
    assign fb       = crc_q[15] ^ payload_q[cnt_q];
    assign crc_step = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);

`ifdef CRC_ERR_INJECT_EN
    assign crc_final = crc_step ^ {15'b0, err_q};
`else
    assign crc_final = crc_step;
`endif

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        payload_d     = payload_q;
        crc_d         = crc_q;
        cnt_d         = cnt_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
`ifdef CRC_ERR_INJECT_EN
        err_d         = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (din_valid) begin
                    payload_d = din;
                    crc_d     = CRC_INIT;
                    cnt_d     = 6'd47;
                    state_d   = CALC;
`ifdef CRC_ERR_INJECT_EN
                    err_d     = err_inj;
`endif
                end
            end
            CALC: begin
                crc_d = crc_step;
                if (cnt_q == 6'd0) begin
                    frame_d       = {payload_q, crc_final};
                    frame_valid_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            DONE: begin
                if (frame_valid_q && frame_ready) begin
                    frame_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign din_ready   = (state_q == IDLE);
    assign busy        = (state_q == CALC);
    assign frame_out   = frame_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_crc48_frame_gen.sv
// Bench for crc48_frame_gen: one default-parameter instance and one with CRC_INIT=0 share stimulus;
// a long-division CRC model fills per-instance scoreboards checked at each handshake.
module tb_crc48_frame_gen;

    logic        clk;
    logic        rst;
    logic [47:0] din;
    logic        din_valid;
    logic        frame_ready;
    logic        err_inj;

    logic        din_ready_a, frame_valid_a, busy_a;
    logic [63:0] frame_out_a;
    logic        din_ready_z, frame_valid_z, busy_z;
    logic [63:0] frame_out_z;

    int vectors     = 0;
    int miscompares = 0;
    int pushes_a = 0, pops_a = 0;
    int pushes_z = 0, pops_z = 0;

    logic [63:0] q_a[$];
    logic [63:0] q_z[$];

    crc48_frame_gen dut_a (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
`ifdef CRC_ERR_INJECT_EN
        .err_inj     (err_inj),
`endif
        .din_ready   (din_ready_a),
        .frame_out   (frame_out_a),
        .frame_valid (frame_valid_a),
        .frame_ready (frame_ready),
        .busy        (busy_a)
    );

    crc48_frame_gen #(.CRC_POLY(16'h1021), .CRC_INIT(16'h0000)) dut_z (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
`ifdef CRC_ERR_INJECT_EN
        .err_inj     (err_inj),
`endif
        .din_ready   (din_ready_z),
        .frame_out   (frame_out_z),
        .frame_valid (frame_valid_z),
        .frame_ready (frame_ready),
        .busy        (busy_z)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // CRC as remainder of (init*x^48 + data*x^16) mod G, by polynomial long division.
    function automatic logic [15:0] crc_model(input logic [47:0] d, input logic [15:0] init);
        logic [63:0] m;
        logic [63:0] g;
        m = {d, 16'h0000} ^ {init, 48'h0};
        for (int i = 63; i >= 16; i--) begin
            if (m[i]) begin
                g = {47'b0, 1'b1, 16'h1021} << (i - 16);
                m = m ^ g;
            end
        end
        return m[15:0];
    endfunction

    function automatic logic inj_bit();
`ifdef CRC_ERR_INJECT_EN
        return err_inj;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Resolve the handshakes the coming falling edge will perform, then advance to mid-cycle.
    task automatic cycle();
        logic [63:0] e;
        if (!rst) begin
            q_a.delete();
            q_z.delete();
            pops_a = pushes_a;
            pops_z = pushes_z;
        end else begin
            if (frame_valid_a && frame_ready) begin
                if (q_a.size() == 0) check("unexpected_frame_a", 64'd1, 64'd0);
                else begin
                    e = q_a.pop_front();
                    check("frame_a", frame_out_a, e);
                    pops_a++;
                end
            end
            if (frame_valid_z && frame_ready) begin
                if (q_z.size() == 0) check("unexpected_frame_z", 64'd1, 64'd0);
                else begin
                    e = q_z.pop_front();
                    check("frame_z", frame_out_z, e);
                    pops_z++;
                end
            end
            if (din_valid && din_ready_a) begin
                q_a.push_back({din, crc_model(din, 16'hFFFF) ^ {15'b0, inj_bit()}});
                pushes_a++;
            end
            if (din_valid && din_ready_z) begin
                q_z.push_back({din, crc_model(din, 16'h0000) ^ {15'b0, inj_bit()}});
                pushes_z++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!frame_valid_a && n < 200) begin
            cycle();
            n++;
        end
        check("valid_timeout", {63'b0, frame_valid_a}, 64'd1);
    endtask

    // Accept one payload, wait for the frame, return the CRC_INIT=0 frame, then consume it.
    task automatic run_frame(input logic [47:0] d, input logic inj, output logic [63:0] fz);
        int n;
        din       = d;
        din_valid = 1'b1;
        err_inj   = inj;
        cycle();
        din_valid = 1'b0;
        err_inj   = 1'b0;
        wait_valid(n);
        fz = frame_out_z;
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;
    endtask

    initial begin
        int          n;
        logic [63:0] fz;
        logic [63:0] held;
        logic [63:0] r;

        rst         = 1'b0;
        din         = '0;
        din_valid   = 1'b0;
        frame_ready = 1'b0;
        err_inj     = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle();

        check("rst_din_ready", {63'b0, din_ready_a}, 64'd1);
        check("rst_frame_valid", {63'b0, frame_valid_a}, 64'd0);
        check("rst_busy", {63'b0, busy_a}, 64'd0);
        check("rst_frame_out", frame_out_a, 64'h0);
        rst = 1'b1;
        cycle();

        // Zero-init vectors: latency and two hand-computed frames.
        din       = 48'h0;
        din_valid = 1'b1;
        cycle();
        din_valid = 1'b0;
        check("calc_busy", {63'b0, busy_z}, 64'd1);
        check("calc_din_ready", {63'b0, din_ready_z}, 64'd0);
        n = 0;
        while (!frame_valid_z && n < 100) begin
            cycle();
            n++;
        end
        check("latency_after_accept", 64'(n), 64'd48);
        check("done_busy", {63'b0, busy_z}, 64'd0);
        check("zero_frame", frame_out_z, 64'h0000_0000_0000_0000);
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;
        check("post_hs_din_ready", {63'b0, din_ready_z}, 64'd1);
        check("post_hs_valid", {63'b0, frame_valid_z}, 64'd0);
        check("retained_frame", frame_out_z, 64'h0);

        run_frame(48'h000000000001, 1'b0, fz);
        check("one_frame", fz, 64'h0000_0000_0001_1021);
        run_frame(48'h000000000002, 1'b0, fz);
        check("two_frame", fz, 64'h0000_0000_0002_2042);

        // Backpressure: held frame, ignored din_valid, release.
        din       = 48'hA5A5_1234_5678;
        din_valid = 1'b1;
        cycle();
        din_valid = 1'b0;
        wait_valid(n);
        held      = frame_out_a;
        din       = 48'h0F0F_0F0F_0F0F;
        din_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("bp_stable", frame_out_a, held);
            check("bp_valid", {63'b0, frame_valid_a}, 64'd1);
            check("bp_din_ready", {63'b0, din_ready_a}, 64'd0);
        end
        frame_ready = 1'b1;
        cycle();
        check("bp_release_ready", {63'b0, din_ready_a}, 64'd1);
        check("bp_release_valid", {63'b0, frame_valid_a}, 64'd0);
        check("bp_no_accept", {63'b0, busy_a}, 64'd0);
        din_valid   = 1'b0;
        frame_ready = 1'b0;
        cycle();

        // Reset in the middle of CALC discards the frame.
        din       = 48'h1357_9BDF_0246;
        din_valid = 1'b1;
        cycle();
        din_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check("mid_rst_valid", {63'b0, frame_valid_a}, 64'd0);
        check("mid_rst_ready", {63'b0, din_ready_a}, 64'd1);
        check("mid_rst_busy", {63'b0, busy_a}, 64'd0);
        run_frame(48'hDEAD_BEEF_CAFE, 1'b0, fz);
        check("post_rst_pops", 64'(pops_a), 64'(pushes_a));

`ifdef CRC_ERR_INJECT_EN
        run_frame(48'h0, 1'b1, fz);
        check("inject_frame", fz, 64'h0000_0000_0000_0001);
        run_frame(48'h0, 1'b0, fz);
        check("inject_cleared", fz, 64'h0000_0000_0000_0000);
`endif

        // Random payloads with random downstream readiness.
        for (int i = 0; i < 1000; i++) begin
            r           = {$urandom, $urandom};
            din         = r[47:0];
            din_valid   = 1'b1;
            frame_ready = ($urandom_range(0, 3) != 0);
            cycle();
            din_valid = 1'b0;
            n = 0;
            while (pops_a < pushes_a && n < 300) begin
                frame_ready = ($urandom_range(0, 3) != 0);
                cycle();
                n++;
            end
            check("rand_drain", 64'(pops_a), 64'(pushes_a));
        end
        frame_ready = 1'b0;
        cycle();

        check("final_q_a_empty", 64'(q_a.size()), 64'd0);
        check("final_q_z_empty", 64'(q_z.size()), 64'd0);
        check("final_counts_match", 64'(pops_z), 64'(pushes_z));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
